// File: rtl/ringosc_meas_ctrl.sv
// Measurement sequencer for the ring-oscillator ripple counter: clear, gate the
// oscillator for gate_len clocks, let the ripple chain settle, then read 64 bits a byte at a time.
module ringosc_meas_ctrl #(
  parameter int GATE_W  = 16,
  parameter int SETTLE  = 4,
  parameter int CLR_CYC = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [GATE_W-1:0] gate_len,
  output logic              osc_stop,
  output logic              cnt_clear,
  output logic [5:0]        cnt_shift,
  input  logic [7:0]        cnt_byte,
  output logic              busy,
  output logic              done,
  output logic              result_valid,
  output logic [63:0]       result
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_RUN,
    S_SETTLE,
    S_READ,
    S_DONE
  } state_t;

  // One shared sequence counter covers the clear hold, settle wait and 16 read cycles.
  localparam int SEQ_MAX0 = (CLR_CYC > SETTLE) ? CLR_CYC : SETTLE;
  localparam int SEQ_MAX  = (SEQ_MAX0 > 16) ? SEQ_MAX0 : 16;
  localparam int SEQ_W    = $clog2(SEQ_MAX);

  localparam logic [SEQ_W-1:0] CLR_LAST    = SEQ_W'(CLR_CYC - 1);
  localparam logic [SEQ_W-1:0] SETTLE_LAST = SEQ_W'(SETTLE - 1);
  localparam logic [SEQ_W-1:0] READ_LAST   = SEQ_W'(15);

  state_t            state_reg;
  logic [GATE_W-1:0] gate_reg;
  logic [SEQ_W-1:0]  seq_reg;
  logic [55:0]       shadow_reg;
  logic [2:0]        slot;
  logic              abortable;

  // During READ the counter walks 0..15: bits [3:1] pick the byte slot, bit 0 is cycle A/B.
  assign slot      = seq_reg[3:1];
  assign abortable = (state_reg == S_CLEAR) || (state_reg == S_RUN) ||
                     (state_reg == S_SETTLE) || (state_reg == S_READ);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= S_IDLE;
      gate_reg     <= '0;
      seq_reg      <= '0;
      shadow_reg   <= '0;
      osc_stop     <= 1'b1;
      cnt_clear    <= 1'b0;
      cnt_shift    <= 6'd0;
      busy         <= 1'b0;
      done         <= 1'b0;
      result_valid <= 1'b0;
      result       <= 64'd0;
    end else begin
      done <= 1'b0;
      if (abort && abortable) begin
        state_reg <= S_IDLE;
        osc_stop  <= 1'b1;
        cnt_clear <= 1'b0;
        cnt_shift <= 6'd0;
        busy      <= 1'b0;
        seq_reg   <= '0;
      end else begin
        case (state_reg)
          S_IDLE: begin
            if (start) begin
              state_reg    <= S_CLEAR;
              gate_reg     <= gate_len;
              seq_reg      <= '0;
              cnt_clear    <= 1'b1;
              osc_stop     <= 1'b1;
              busy         <= 1'b1;
              result_valid <= 1'b0;
            end
          end

          S_CLEAR: begin
            if (seq_reg == CLR_LAST) begin
              cnt_clear <= 1'b0;
              seq_reg   <= '0;
              if (gate_reg == '0) begin
                state_reg <= S_SETTLE;
              end else begin
                // Preloading gate-1 makes the low window exactly gate_len cycles.
                state_reg <= S_RUN;
                osc_stop  <= 1'b0;
                gate_reg  <= gate_reg - GATE_W'(1);
              end
            end else begin
              seq_reg <= seq_reg + SEQ_W'(1);
            end
          end

          S_RUN: begin
            if (gate_reg == '0) begin
              state_reg <= S_SETTLE;
              osc_stop  <= 1'b1;
              seq_reg   <= '0;
            end else begin
              gate_reg <= gate_reg - GATE_W'(1);
            end
          end

          S_SETTLE: begin
            if (seq_reg == SETTLE_LAST) begin
              state_reg <= S_READ;
              seq_reg   <= '0;
              cnt_shift <= 6'd0;
            end else begin
              seq_reg <= seq_reg + SEQ_W'(1);
            end
          end

          S_READ: begin
            seq_reg <= seq_reg + SEQ_W'(1);
            if (seq_reg[0]) begin
              for (int b = 0; b < 7; b++) begin
                if (slot == 3'(b)) shadow_reg[8*b +: 8] <= cnt_byte;
              end
              if (seq_reg == READ_LAST) begin
                // The top byte goes straight into result on the commit edge.
                state_reg    <= S_DONE;
                result       <= {cnt_byte, shadow_reg};
                result_valid <= 1'b1;
                done         <= 1'b1;
                cnt_shift    <= 6'd0;
                seq_reg      <= '0;
              end else begin
                cnt_shift <= {slot + 3'd1, 3'b000};
              end
            end
          end

          S_DONE: begin
            state_reg <= S_IDLE;
            busy      <= 1'b0;
          end

          default: begin
            state_reg <= S_IDLE;
            osc_stop  <= 1'b1;
            cnt_clear <= 1'b0;
            cnt_shift <= 6'd0;
            busy      <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ringosc_meas_ctrl.sv
// Bench for ringosc_meas_ctrl: a behavioural ripple counter adds inc per enabled clock;
// expected results are computed as inc*gate_len with plain arithmetic.
module tb_ringosc_meas_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [15:0] gate_len = 16'd0;
  logic        osc_stop;
  logic        cnt_clear;
  logic [5:0]  cnt_shift;
  logic [7:0]  cnt_byte;
  logic        busy;
  logic        done;
  logic        result_valid;
  logic [63:0] result;

  int tests = 0;
  int fails = 0;

  logic [63:0] ctr = 64'd0;
  logic [63:0] inc = 64'd3;
  int low_total  = 0;
  int done_total = 0;

  ringosc_meas_ctrl #(.GATE_W(16), .SETTLE(4), .CLR_CYC(2)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .gate_len(gate_len),
    .osc_stop(osc_stop), .cnt_clear(cnt_clear), .cnt_shift(cnt_shift),
    .cnt_byte(cnt_byte), .busy(busy), .done(done),
    .result_valid(result_valid), .result(result)
  );

  always #5 clk = ~clk;

  // External ripple counter: cleared by cnt_clear, counts only while the oscillator runs.
  always @(posedge clk) begin
    if (cnt_clear) ctr <= 64'd0;
    else if (!osc_stop) ctr <= ctr + inc;
  end
  assign cnt_byte = 8'(ctr >> cnt_shift);

  always @(negedge clk) begin
    if (osc_stop === 1'b0) low_total <= low_total + 1;
    if (done === 1'b1) done_total <= done_total + 1;
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", name, got, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_osc_stop"}, 64'(osc_stop), 64'd1);
    check({tag, "_cnt_clear"}, 64'(cnt_clear), 64'd0);
    check({tag, "_cnt_shift"}, 64'(cnt_shift), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
    check({tag, "_valid"}, 64'(result_valid), 64'd0);
    check({tag, "_result"}, result, 64'd0);
  endtask

  // Full measurement: checks E0 outputs, start-to-done latency, low time, result and busy fall.
  task automatic meas(input logic [15:0] g, input logic [63:0] inc_v, input string tag);
    int cyc;
    int low0;
    int d0;
    @(negedge clk);
    inc = inc_v;
    gate_len = g;
    start = 1'b1;
    low0 = low_total;
    d0 = done_total;
    @(posedge clk);
    #1 start = 1'b0;
    check({tag, "_e0_busy"}, 64'(busy), 64'd1);
    check({tag, "_e0_clear"}, 64'(cnt_clear), 64'd1);
    check({tag, "_e0_valid"}, 64'(result_valid), 64'd0);
    cyc = 0;
    while (done !== 1'b1 && cyc < int'(g) + 60) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check({tag, "_latency"}, 64'(cyc), 64'(22 + int'(g)));
    check({tag, "_result"}, result, inc_v * 64'(g));
    check({tag, "_valid"}, 64'(result_valid), 64'd1);
    check({tag, "_osc_low"}, 64'(low_total - low0), 64'(g));
    @(posedge clk);
    #1;
    check({tag, "_busy_fall"}, 64'(busy), 64'd0);
    check({tag, "_done_pulse"}, 64'(done), 64'd0);
    check({tag, "_done_count"}, 64'(done_total - d0), 64'd1);
  endtask

  initial begin
    int cyc;
    int low0;
    int d0;

    // Asynchronous reset before any clock edge
    #3 rst = 1'b1;
    #1 check_reset_outputs("rst_async");
    @(negedge clk) rst = 1'b0;
    repeat (10) @(posedge clk);
    #1 check_reset_outputs("rst_idle");

    meas(16'd100, 64'd3, "nominal");
    meas(16'd1, 64'h0123456789ABCDEF, "byte_order");
    meas(16'd0, 64'd3, "zero_gate");
    meas(16'd40, 64'd5, "pre_reset");

    // Reset in the middle of RUN drops everything at once
    @(negedge clk);
    inc = 64'd3;
    gate_len = 16'd20;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(posedge clk);
    #1 check("midrst_running", 64'(osc_stop), 64'd0);
    #1 rst = 1'b1;
    #1 check_reset_outputs("midrst");
    @(negedge clk) rst = 1'b0;
    repeat (10) @(posedge clk);
    #1 check_reset_outputs("midrst_idle");

    // Starts while busy (in RUN and in DONE) are ignored
    @(negedge clk);
    inc = 64'd3;
    gate_len = 16'd50;
    start = 1'b1;
    d0 = done_total;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(posedge clk);
    #1 gate_len = 16'd7;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    cyc = 0;
    while (done !== 1'b1 && cyc < 200) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check("busy_start_done_seen", 64'(done), 64'd1);
    gate_len = 16'd7;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    check("busy_start_busy_fall", 64'(busy), 64'd0);
    repeat (100) @(posedge clk);
    #1;
    check("busy_start_done_count", 64'(done_total - d0), 64'd1);
    check("busy_start_idle", 64'(busy), 64'd0);
    check("busy_start_result", result, 64'd150);

    // Abort in cycle 30 of RUN
    @(negedge clk);
    inc = 64'd3;
    gate_len = 16'd100;
    start = 1'b1;
    low0 = low_total;
    d0 = done_total;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (31) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    check("abort_osc_stop", 64'(osc_stop), 64'd1);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_valid", 64'(result_valid), 64'd0);
    check("abort_result", result, 64'd150);
    repeat (150) @(posedge clk);
    #1;
    check("abort_no_done", 64'(done_total - d0), 64'd0);
    check("abort_osc_low", 64'(low_total - low0), 64'd30);
    check("abort_valid_hold", 64'(result_valid), 64'd0);
    meas(16'd60, 64'd3, "after_abort");

    // Randomized gate lengths and increments
    for (int i = 0; i < 6; i++) begin
      meas(16'($urandom_range(0, 300)), {$urandom, $urandom}, $sformatf("rand%0d", i));
    end

    meas(16'hFFFF, 64'd1, "max_gate");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
